hw_accel_dma_stream_engine: RTL

DMA-side stream endpoint that pairs with the hardware-accelerator wrapper: it sources one frame of pixel words on the MM2S read stream (`dma_rvalid`/`dma_rready`/`dma_rkeep`/`dma_rdata`) and sinks the processed frame on the S2MM write stream (`dma_wvalid`/`dma_wready`/`dma_wlast`/`dma_wdata`). It drives `hw_accel_dma_init_done` to launch the accelerator's write side, checks `wlast` burst framing, and reports counts, checksum and errors. It is used for standalone accelerator bring-up on hardware and as the bench-side driver, with no DDR or DMA controller involved.

---
 rtl/hw_accel_dma_stream_engine_if.sv | 36 +++
 rtl/hw_accel_dma_stream_engine.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/hw_accel_dma_stream_engine_if.sv
// Stream bundle between the DMA-side engine and the accelerator.
// master: engine (MM2S source, S2MM sink); slave: accelerator.
interface hw_accel_dma_stream_engine_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    dma_rready;
  logic                    dma_rvalid;
  logic [DATA_WIDTH/8-1:0] dma_rkeep;
  logic [DATA_WIDTH-1:0]   dma_rdata;
  logic                    dma_wready;
  logic                    dma_wvalid;
  logic                    dma_wlast;
  logic [DATA_WIDTH-1:0]   dma_wdata;

  modport master (
    input  dma_rready,
    output dma_rvalid,
    output dma_rkeep,
    output dma_rdata,
    output dma_wready,
    input  dma_wvalid,
    input  dma_wlast,
    input  dma_wdata
  );

  modport slave (
    output dma_rready,
    input  dma_rvalid,
    input  dma_rkeep,
    input  dma_rdata,
    input  dma_wready,
    output dma_wvalid,
    output dma_wlast,
    output dma_wdata
  );
endinterface

// File: rtl/hw_accel_dma_stream_engine.sv
// Frame source/sink endpoint for accelerator bring-up.
// Ports: clk/rst, start, wr_stall, status, dma bundle, counters/errors.
module hw_accel_dma_stream_engine #(
  parameter int DATA_WIDTH          = 32,
  parameter int FRAME_WIDTH         = 640,
  parameter int FRAME_HEIGHT        = 480,
  parameter int DMA_TRANSFER_LENGTH = 1920,
  parameter int TIMEOUT_CYCLES      = 1048576
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic wr_stall,
  output logic hw_accel_dma_init_done,
  output logic busy,
  output logic done,
  hw_accel_dma_stream_engine_if.master dma,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] wr_checksum,
  output logic [7:0]  frame_seq,
  output logic        err_wlast,
  output logic        err_timeout
);

  localparam int KW = DATA_WIDTH / 8;
  localparam logic [31:0] TOTAL =
    32'(FRAME_WIDTH * FRAME_HEIGHT);
  localparam logic [31:0] BURST_LAST =
    32'(DMA_TRANSFER_LENGTH - 1);
  localparam logic [31:0] TO_MAX =
    32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0] rd_q, rd_d;
  logic [31:0] wr_q, wr_d;
  logic [31:0] sum_q, sum_d;
  logic [31:0] burst_q, burst_d;
  logic [31:0] wd_q, wd_d;
  logic [7:0]  seq_q, seq_d;
  logic        errl_q, errl_d;
  logic        errt_q, errt_d;
  logic        busy_q, busy_d;
  logic        init_q, init_d;
  logic        done_q, done_d;
  logic        rvalid_q, rvalid_d;
  logic [KW-1:0]         rkeep_q, rkeep_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic wready;
  logic rd_hs;
  logic wr_hs;
  logic last_exp;

  // wready is the only combinational output
  assign wready = (state_q == RUN) && !wr_stall
                && (wr_q < TOTAL);
  assign rd_hs    = rvalid_q && dma.dma_rready;
  assign wr_hs    = dma.dma_wvalid && wready;
  assign last_exp = (burst_q == BURST_LAST);

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    sum_d   = sum_q;
    burst_d = burst_q;
    wd_d    = wd_q;
    seq_d   = seq_q;
    errl_d  = errl_q;
    errt_d  = errt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          rd_d    = '0;
          wr_d    = '0;
          sum_d   = '0;
          burst_d = '0;
          wd_d    = '0;
          errl_d  = 1'b0;
          errt_d  = 1'b0;
        end
      end
      RUN: begin
        if (rd_hs) rd_d = rd_q + 32'd1;
        if (wr_hs) begin
          wr_d    = wr_q + 32'd1;
          sum_d   = sum_q + dma.dma_wdata[31:0];
          burst_d = last_exp ? '0 : burst_q + 32'd1;
          if (dma.dma_wlast != last_exp) errl_d = 1'b1;
        end
        if (rd_hs || wr_hs) wd_d = '0;
        else                wd_d = wd_q + 32'd1;
        // completion wins over a coincident watchdog trip
        if (rd_d == TOTAL && wr_d == TOTAL) begin
          state_d = DONE;
        end else if (!(rd_hs || wr_hs) && wd_d == TO_MAX) begin
          errt_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        seq_d   = seq_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase

    // registered outputs follow the next state
    busy_d   = (state_d != IDLE);
    init_d   = (state_d == RUN);
    done_d   = (state_d == DONE);
    rvalid_d = (state_d == RUN) && (rd_d < TOTAL);
    rkeep_d  = {KW{rvalid_d}};
    rdata_d  = rdata_q;
    if (state_d == RUN)
      rdata_d = DATA_WIDTH'({seq_q, rd_d[23:0]});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_q     <= '0;
      wr_q     <= '0;
      sum_q    <= '0;
      burst_q  <= '0;
      wd_q     <= '0;
      seq_q    <= '0;
      errl_q   <= 1'b0;
      errt_q   <= 1'b0;
      busy_q   <= 1'b0;
      init_q   <= 1'b0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rkeep_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      sum_q    <= sum_d;
      burst_q  <= burst_d;
      wd_q     <= wd_d;
      seq_q    <= seq_d;
      errl_q   <= errl_d;
      errt_q   <= errt_d;
      busy_q   <= busy_d;
      init_q   <= init_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      rkeep_q  <= rkeep_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dma.dma_rvalid = rvalid_q;
  assign dma.dma_rkeep  = rkeep_q;
  assign dma.dma_rdata  = rdata_q;
  assign dma.dma_wready = wready;

  assign hw_accel_dma_init_done = init_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rd_count    = rd_q;
  assign wr_count    = wr_q;
  assign wr_checksum = sum_q;
  assign frame_seq   = seq_q;
  assign err_wlast   = errl_q;
  assign err_timeout = errt_q;

endmodule
